// File: rtl/mem_access_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_port_pkg
// Description : Shared definitions for the memory access port: access size
//               codes, FSM state encoding and the request legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_port_pkg;

    // Access size codes carried on req_size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    // Responder FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR      = 3'd2,
        ST_RESP    = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    // A request is illegal when its size code is reserved, it is not
    // naturally aligned, or its start address lies past the last byte.
    function automatic logic is_illegal(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] addr_max);
        logic bad;
        bad = 1'b0;
        if (size == SZ_BAD)                          bad = 1'b1;
        if ((size == SZ_HALF) && addr[0])            bad = 1'b1;
        if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) bad = 1'b1;
        if (addr > addr_max)                         bad = 1'b1;
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_port_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_port_if
// Description : Request/response handshake plus memory-side bus of the
//               memory access port.
//               slave  : the access port (drives req_ready, rsp_*, mem_addr,
//                        mem_we, mem_wdata)
//               master : control FSM + memory (drives req_*, mem_rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_port_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_port_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_unit
// Description : Combinational big-endian lane logic.
//               Extract path : pick byte/half at offset from word_i and
//                              sign/zero extend into rdata_o.
//               Merge path   : replace the addressed byte/half lanes of
//                              word_i with wdata_i, giving merged_o.
// Ports       : size_i, signed_i, offset_i, word_i, wdata_i -> rdata_o,
//               merged_o
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_unit
    import mem_access_port_pkg::*;
(
    input  wire logic [1:0]  size_i,
    input  wire logic        signed_i,
    input  wire logic [1:0]  offset_i,
    input  wire logic [31:0] word_i,
    input  wire logic [15:0] wdata_i,
    output logic      [31:0] rdata_o,
    output logic      [31:0] merged_o
);

    // Big-endian: offset 0 is the most significant lane, so the lane's
    // LSB position is (3 - offset) * 8 for bytes, (2 - offset) * 8 for halves.
    logic [4:0] byte_lsb;
    logic [4:0] half_lsb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_lsb = {~offset_i, 3'b000};
    assign half_lsb = {~offset_i[1], 4'b0000};
    assign byte_sel = word_i[byte_lsb +: 8];
    assign half_sel = word_i[half_lsb +: 16];

    always_comb begin
        rdata_o  = '0;
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                rdata_o                 = {{24{signed_i & byte_sel[7]}}, byte_sel};
                merged_o[byte_lsb +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                rdata_o                  = {{16{signed_i & half_sel[15]}}, half_sel};
                merged_o[half_lsb +: 16] = wdata_i;
            end
            SZ_WORD: begin
                rdata_o = word_i;
            end
            default: begin
                rdata_o = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_port
// Description : Memory-side responder for CPU loads/stores. One request at a
//               time; byte/half/word loads with sign/zero extension, word
//               stores direct, sub-word stores by read-modify-write. Illegal
//               requests (size 11, misaligned, out of range) get an error
//               response without touching memory.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - mem_access_port_if.slave (request, response, memory)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_port
    import mem_access_port_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned RD_LAT    = 1
)(
    input  wire logic           clk,
    input  wire logic           reset,
    mem_access_port_if.slave    bus
);

    localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 1);
    // RD_WAIT lasts RD_LAT cycles; the counter runs RD_LAT-1 down to 0.
    localparam logic [7:0]  CNT_LOAD = 8'(RD_LAT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] ext_rdata;
    logic [31:0] merge_word;
    logic        req_bad;

    assign req_bad = is_illegal(bus.req_size, bus.req_addr, ADDR_MAX);

    byte_lane_unit u_lane (
        .size_i   (size_q),
        .signed_i (signed_q),
        .offset_i (off_q),
        .word_i   (bus.mem_rdata),
        .wdata_i  (wdata_q),
        .rdata_o  (ext_rdata),
        .merged_o (merge_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // Response outputs are single-cycle pulses unless set below.
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        off_q    <= bus.req_addr[1:0];
                        wdata_q  <= bus.req_wdata[15:0];
                        if (req_bad) begin
                            state_q     <= ST_ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                            if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                                mem_wdata_q <= bus.req_wdata;
                                state_q     <= ST_WR;
                            end else begin
                                cnt_q   <= CNT_LOAD;
                                state_q <= ST_RD_WAIT;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        // mem_rdata is valid on this last wait cycle.
                        if (we_q) begin
                            mem_wdata_q <= merge_word;
                            state_q     <= ST_WR;
                        end else begin
                            rsp_rdata_q <= ext_rdata;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_WR: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP, ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // mem_we is a pure state decode so an asynchronous reset removes it
    // before the next edge and an interrupted store never lands.
    assign bus.mem_we    = (state_q == ST_WR);
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_port
// Description : Directed self-checking bench for mem_access_port with a
//               combinational-read word memory model (RD_LAT = 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_port;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   we_cnt;
    int   rsp_cnt;

    logic [31:0] mem [0:63];

    mem_access_port_if bus ();

    mem_access_port #(
        .MEM_BYTES (256),
        .RD_LAT    (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One request, then wait for its response and check latency, error flag,
    // data, held address and the number of memory write strobes.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int n;
        int we0;
        int exp_we;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        chk({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
        we0 = we_cnt;
        @(posedge clk);
        #1;
        // Scramble fields: the port must use the values captured at acceptance.
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_size   = 2'b11;
        bus.req_signed = ~sgn;
        bus.req_addr   = 32'h0000_0003;
        bus.req_wdata  = ~wd;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) break;
        end
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
        chk({tag, " rdata"}, bus.rsp_rdata, exp_rd);
        if (!exp_err) chk({tag, " mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        exp_we = (we && !exp_err) ? 1 : 0;
        chk({tag, " we_count"}, we_cnt - we0, exp_we);
        @(negedge clk);
        chk({tag, " pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int r0;
        checks  = 0;
        errors  = 0;
        we_cnt  = 0;
        rsp_cnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h80FF_1234;
        mem[63] = 32'h0000_00C3;

        reset          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0000_0010;
        bus.req_wdata  = 32'hFFFF_FFFF;

        // Held in reset across edges with a pending request: all outputs quiet.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        chk("rst rsp_rdata", bus.rsp_rdata,          32'd0);
        chk("rst mem_we",    {31'd0, bus.mem_we},    32'd0);
        chk("rst mem_addr",  bus.mem_addr,           32'd0);
        chk("rst mem_wdata", bus.mem_wdata,          32'd0);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("post-rst ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post-rst mem",   mem[4], 32'h80FF_1234);

        // Loads: byte/half, signed/unsigned, big-endian lanes
        do_req("lb 0x10",  1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'hFFFF_FF80);
        do_req("lbu 0x11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 1'b0, 32'h0000_00FF);
        do_req("lh 0x12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'h0000_1234);
        do_req("lhu 0x10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h0000_80FF);
        do_req("lh 0x11",  1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1, 1'b1, 32'h0);
        do_req("lb 0xFF",  1'b0, 2'b00, 1'b1, 32'hFF, 32'h0, 2, 1'b0, 32'hFFFF_FFC3);

        // Sub-word stores via read-modify-write
        do_req("sb 0x13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_56AB, 3, 1'b0, 32'h0);
        chk("sb mem", mem[4], 32'h80FF_12AB);
        do_req("sh 0x10", 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_BEEF, 3, 1'b0, 32'h0);
        chk("sh mem", mem[4], 32'hBEEF_12AB);

        // Word store / load and illegal accesses
        do_req("sw 0x20",  1'b1, 2'b10, 1'b0, 32'h20,  32'hDEAD_BEEF, 2, 1'b0, 32'h0);
        chk("sw mem", mem[8], 32'hDEAD_BEEF);
        do_req("lw 0x20",  1'b0, 2'b10, 1'b0, 32'h20,  32'h0, 2, 1'b0, 32'hDEAD_BEEF);
        do_req("sw 0x100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h1111_1111, 1, 1'b1, 32'h0);
        do_req("lw 0x22",  1'b0, 2'b10, 1'b0, 32'h22,  32'h0, 1, 1'b1, 32'h0);
        do_req("size 11",  1'b1, 2'b11, 1'b0, 32'h10,  32'h0, 1, 1'b1, 32'h0);
        chk("err mem", mem[4], 32'hBEEF_12AB);

        // Back-to-back with req_valid held high
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h20;
        @(posedge clk);
        #1;
        bus.req_addr = 32'h10;
        @(negedge clk);
        chk("b2b busy ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b rsp1 valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("b2b rsp1 rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("b2b resp ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b gap valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("b2b gap rdata", bus.rsp_rdata, 32'd0);
        chk("b2b idle ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b busy2 ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b rsp2 valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("b2b rsp2 rdata", bus.rsp_rdata, 32'hBEEF_12AB);

        // Reset during the WR cycle of a sub-word store
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b01;
        bus.req_addr   = 32'h12;
        bus.req_wdata  = 32'h0000_5555;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        r0 = rsp_cnt;
        @(posedge clk);
        @(negedge clk);
        chk("abort mem_we before", {31'd0, bus.mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort mem_we after", {31'd0, bus.mem_we}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort mem", mem[4], 32'hBEEF_12AB);
        chk("abort no rsp", rsp_cnt - r0, 32'd0);
        chk("abort ready", {31'd0, bus.req_ready}, 32'd1);

        // Port is usable again after the abort
        do_req("lw 0x10 post", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hBEEF_12AB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
